// File: rtl/alu_pkg.sv
// Shared definitions for the Y86 ALU: ifun encodings, condition-code bit
// positions and the controller state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational Y86 ALU (ADD/SUB/AND/XOR) with ZF/SF/OF generation.
// Unknown ifun values produce a zero result and raise illegal.
module alu_core
    import alu_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         zf,
    output logic         sf,
    output logic         of,
    output logic         illegal
);

    // SUB follows subq semantics: the result is b - a.
    always_comb begin
        result  = '0;
        of      = 1'b0;
        illegal = 1'b0;
        case (op)
            ALU_ADD: begin
                result = a + b;
                of     = (a[W-1] == b[W-1]) && (result[W-1] != a[W-1]);
            end
            ALU_SUB: begin
                result = b - a;
                of     = (a[W-1] != b[W-1]) && (result[W-1] != b[W-1]);
            end
            ALU_AND: result = a & b;
            ALU_XOR: result = a ^ b;
            default: illegal = 1'b1;
        endcase
        zf = (result == '0);
        sf = result[W-1];
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one alu_core between the execute stage (port 0) and the debug port
// (port 1): round-robin grant, one-cycle execute, valid/ready response, CC register.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int W    = 64,
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [3:0]      req_op0,
    input  logic [3:0]      req_op1,
    input  logic [W-1:0]    req_a0,
    input  logic [W-1:0]    req_a1,
    input  logic [W-1:0]    req_b0,
    input  logic [W-1:0]    req_b1,
    input  logic [NREQ-1:0] req_setcc,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [W-1:0]    rsp_result,
    output logic            rsp_err,
    output logic [2:0]      cc_out,
    output logic            busy
);

    state_t         state;
    state_t         state_nxt;
    logic           grant;
    logic           grant_fire;
    logic           last_grant;

    logic [3:0]     op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           setcc_q;
    logic           id_q;
    logic [W-1:0]   result_q;
    logic           err_q;
    logic [2:0]     cc_q;

    logic [W-1:0]   core_result;
    logic           core_zf;
    logic           core_sf;
    logic           core_of;
    logic           core_illegal;

    alu_core #(.W(W)) u_core (
        .op      (op_q),
        .a       (a_q),
        .b       (b_q),
        .result  (core_result),
        .zf      (core_zf),
        .sf      (core_sf),
        .of      (core_of),
        .illegal (core_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // With both requesting, the port that did not win last time is chosen.
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        grant_fire = 1'b0;
        grant      = (&req_valid) ? ~last_grant : req_valid[1];
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    grant_fire       = 1'b1;
                    req_ready[grant] = 1'b1;
                    state_nxt        = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            setcc_q    <= 1'b0;
            id_q       <= 1'b0;
            result_q   <= '0;
            err_q      <= 1'b0;
            cc_q       <= 3'b100;
        end else begin
            if (grant_fire) begin
                last_grant <= grant;
                id_q       <= grant;
                op_q       <= grant ? req_op1 : req_op0;
                a_q        <= grant ? req_a1 : req_a0;
                b_q        <= grant ? req_b1 : req_b0;
                setcc_q    <= req_setcc[grant];
            end
            // Illegal ops never disturb the architectural flags.
            if (state == EXEC) begin
                result_q <= core_result;
                err_q    <= core_illegal;
                if (setcc_q && !core_illegal) begin
                    cc_q[CC_ZF] <= core_zf;
                    cc_q[CC_SF] <= core_sf;
                    cc_q[CC_OF] <= core_of;
                end
            end
        end
    end

    assign rsp_valid  = (state == RESP);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_err    = err_q;
    assign cc_out     = cc_q;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: directed cases followed by randomized
// two-port traffic, checked against an arithmetic reference model.
module tb_alu_share_ctrl;
    import alu_pkg::*;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [3:0]   req_op0, req_op1;
    logic [W-1:0] req_a0, req_a1, req_b0, req_b1;
    logic [1:0]   req_setcc;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_result;
    logic         rsp_err;
    logic [2:0]   cc_out;
    logic         busy;

    alu_share_ctrl #(.W(W), .NREQ(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .req_a0     (req_a0),
        .req_a1     (req_a1),
        .req_b0     (req_b0),
        .req_b1     (req_b1),
        .req_setcc  (req_setcc),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .cc_out     (cc_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         id;
        logic [W-1:0] result;
        logic         err;
        logic [2:0]   cc;
        int           acc_cyc;
    } exp_t;

    exp_t         sbq[$];
    int           grant_log[$];
    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    logic [2:0]   m_cc = 3'b100;
    logic         m_last = 1'b1;
    logic         m_busy = 1'b0;
    bit           in_resp = 1'b0;
    bit           rand_ready = 1'b0;
    bit           log_grants = 1'b0;
    logic [1:0]   m_exp_ready;
    exp_t         m_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic signed [W+1:0] sx(input logic [W-1:0] v);
        return $signed({{2{v[W-1]}}, v});
    endfunction

    // Overflow = the exact signed result differs from the wrapped W-bit result.
    function automatic void refModel(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic setcc, input logic [2:0] cc_in,
                                     output logic [W-1:0] res, output logic err, output logic [2:0] cc_new);
        logic signed [W+1:0] exact;
        logic ov;
        res = '0; err = 1'b0; ov = 1'b0;
        case (op)
            4'd0: begin res = a + b; exact = sx(a) + sx(b); ov = (exact != sx(res)); end
            4'd1: begin res = b - a; exact = sx(b) - sx(a); ov = (exact != sx(res)); end
            4'd2: res = a & b;
            4'd3: res = a ^ b;
            default: err = 1'b1;
        endcase
        cc_new = cc_in;
        if (!err && setcc) cc_new = {res == '0, res[W-1], ov};
    endfunction

    task automatic syncDrive();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic applyStimulus(input int port, input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic setcc);
        bit done = 1'b0;
        if (port == 0) begin req_op0 = op; req_a0 = a; req_b0 = b; end
        else           begin req_op1 = op; req_a1 = a; req_b1 = b; end
        req_setcc[port] = setcc;
        req_valid[port] = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (req_ready[port]) done = 1'b1;
        end
        if (!done) begin
            tests++; fails++;
            $display("[TB] FAIL handshake_timeout port %0d: got no req_ready, expected req_ready within 200 cycles", port);
        end
        @(posedge clk);
        #1;
        req_valid[port] = 1'b0;
    endtask

    task automatic waitResponse();
        bit got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        if (!got) begin
            tests++; fails++;
            $display("[TB] FAIL rsp_timeout: got rsp_valid=0, expected rsp_valid=1 within 50 cycles");
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 400 && (sbq.size() != 0 || m_busy); t++) @(negedge clk);
        checkOutput("drain_empty", 64'(sbq.size()), 64'd0);
    endtask

    function automatic logic [W-1:0] randVal();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return '1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Monitor: arbitration/busy model, response scoreboard, expected-value pushes.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sbq.delete();
                m_cc = 3'b100; m_last = 1'b1; m_busy = 1'b0; in_resp = 1'b0;
                continue;
            end
            if (m_busy)                 m_exp_ready = 2'b00;
            else if (req_valid == 2'b11) m_exp_ready = m_last ? 2'b01 : 2'b10;
            else                         m_exp_ready = req_valid;
            checkOutput("req_ready", 64'(req_ready), 64'(m_exp_ready));
            checkOutput("busy", 64'(busy), 64'(m_busy));
            if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    tests++; fails++;
                    $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 id=%0d result=%0h, expected no response", rsp_id, rsp_result);
                end else begin
                    m_e = sbq[0];
                    if (!in_resp) checkOutput("latency", 64'(cyc - m_e.acc_cyc), 64'd2);
                    checkOutput("rsp_id", 64'(rsp_id), 64'(m_e.id));
                    checkOutput("rsp_result", rsp_result, m_e.result);
                    checkOutput("rsp_err", 64'(rsp_err), 64'(m_e.err));
                    checkOutput("cc_out", 64'(cc_out), 64'(m_e.cc));
                    if (rsp_ready) begin
                        void'(sbq.pop_front());
                        in_resp = 1'b0;
                        m_busy  = 1'b0;
                    end else begin
                        in_resp = 1'b1;
                    end
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    refModel(i == 0 ? req_op0 : req_op1, i == 0 ? req_a0 : req_a1,
                             i == 0 ? req_b0 : req_b1, req_setcc[i], m_cc,
                             m_e.result, m_e.err, m_e.cc);
                    m_e.id      = (i == 1);
                    m_e.acc_cyc = cyc;
                    m_cc        = m_e.cc;
                    m_last      = (i == 1);
                    m_busy      = 1'b1;
                    sbq.push_back(m_e);
                    if (log_grants) grant_log.push_back(i);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; req_valid = 2'b00; req_setcc = 2'b00; rsp_ready = 1'b1;
        req_op0 = '0; req_op1 = '0; req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_rsp_id", 64'(rsp_id), 64'd0);
        checkOutput("rst_rsp_result", rsp_result, 64'd0);
        checkOutput("rst_rsp_err", 64'(rsp_err), 64'd0);
        checkOutput("rst_cc", 64'(cc_out), 64'b100);
        checkOutput("rst_busy", 64'(busy), 64'd0);

        applyStimulus(0, ALU_XOR, 64'hAAAA_AAAA_AAAA_AAAB, 64'h5555_5555_5555_5555, 1'b1);
        waitResponse();
        checkOutput("xor_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFE);
        checkOutput("xor_id", 64'(rsp_id), 64'd0);
        checkOutput("xor_cc", 64'(cc_out), 64'b010);

        syncDrive();
        applyStimulus(0, ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        waitResponse();
        checkOutput("addov_result", rsp_result, 64'h8000_0000_0000_0000);
        checkOutput("addov_cc", 64'(cc_out), 64'b011);

        syncDrive();
        applyStimulus(1, ALU_SUB, 64'd15, 64'd15, 1'b1);
        waitResponse();
        checkOutput("sub_result", rsp_result, 64'd0);
        checkOutput("sub_id", 64'(rsp_id), 64'd1);
        checkOutput("sub_cc", 64'(cc_out), 64'b100);

        // Backpressure with port 0 waiting behind the stalled response.
        syncDrive();
        rsp_ready = 1'b0;
        applyStimulus(1, ALU_AND, 64'hF0F0, 64'hFF00, 1'b0);
        fork
            applyStimulus(0, ALU_XOR, 64'd5, 64'd3, 1'b1);
            begin
                waitResponse();
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("bp_valid", 64'(rsp_valid), 64'd1);
                    checkOutput("bp_result", rsp_result, 64'hF000);
                    checkOutput("bp_req_ready", 64'(req_ready), 64'd0);
                    checkOutput("bp_busy", 64'(busy), 64'd1);
                end
                syncDrive();
                rsp_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                checkOutput("bp_idle_busy", 64'(busy), 64'd0);
                checkOutput("bp_idle_valid", 64'(rsp_valid), 64'd0);
            end
        join
        waitResponse();
        checkOutput("bp_next_result", rsp_result, 64'd6);
        checkOutput("bp_next_cc", 64'(cc_out), 64'b000);

        syncDrive();
        applyStimulus(1, 4'h7, 64'd1, 64'd2, 1'b1);
        waitResponse();
        checkOutput("ill_err", 64'(rsp_err), 64'd1);
        checkOutput("ill_result", rsp_result, 64'd0);
        checkOutput("ill_cc", 64'(cc_out), 64'b000);

        syncDrive();
        applyStimulus(0, ALU_ADD, 64'd5, 64'd6, 1'b0);
        waitResponse();
        checkOutput("nosetcc_result", rsp_result, 64'd11);
        checkOutput("nosetcc_cc", 64'(cc_out), 64'b000);

        // Reset in the middle of EXEC; the request must vanish.
        syncDrive();
        applyStimulus(0, ALU_XOR, 64'd1, 64'd2, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("arst_busy", 64'(busy), 64'd0);
        checkOutput("arst_result", rsp_result, 64'd0);
        checkOutput("arst_err", 64'(rsp_err), 64'd0);
        checkOutput("arst_id", 64'(rsp_id), 64'd0);
        checkOutput("arst_cc", 64'(cc_out), 64'b100);
        syncDrive();
        rst_n = 1'b1;

        log_grants = 1'b1;
        fork
            begin
                applyStimulus(0, ALU_XOR, 64'd15, 64'd32, 1'b0);
                applyStimulus(0, ALU_XOR, 64'd15, 64'd32, 1'b0);
            end
            begin
                applyStimulus(1, ALU_AND, 64'd31, 64'd63, 1'b0);
                applyStimulus(1, ALU_AND, 64'd31, 64'd63, 1'b0);
            end
        join
        drain();
        log_grants = 1'b0;
        checkOutput("arb_count", 64'(grant_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            checkOutput("arb_order", 64'(grant_log[i]), 64'(i % 2));

        rand_ready = 1'b1;
        fork
            for (int p = 0; p < 2; p++) begin
                automatic int port = p;
                fork
                    for (int n = 0; n < 25; n++) begin
                        automatic int r = $urandom_range(0, 9);
                        automatic logic [3:0] op = (r < 8) ? 4'(r % 4) : 4'($urandom_range(4, 15));
                        repeat ($urandom_range(0, 3)) syncDrive();
                        applyStimulus(port, op, randVal(), randVal(), 1'($urandom_range(0, 1)));
                    end
                join_none
            end
        join
        wait fork;
        rand_ready = 1'b0;
        syncDrive();
        rsp_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Multi-cycle controller that shares one 64-bit Y86 ALU (ADD/SUB/AND/XOR) between two requesters: port 0 is the execute stage, port 1 is the debug/self-test port.
- Arbitrates requests round-robin, registers operands, drives the combinational ALU core, and captures the result.
- Maintains the architectural condition-code register (ZF, SF, OF) and returns each result over a valid/ready response channel.

Parameters:
- W, 64, operand/result width in bits.
- NREQ, 2, number of requesters; fixed at 2 for this revision.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept; one-hot or zero.
- req_op0 / req_op1  in  4  Y86 ifun for requester 0/1.
- req_a0 / req_a1  in  W  operand A (valA).
- req_b0 / req_b1  in  W  operand B (valB).
- req_setcc  in  2  per-requester: update CC on completion.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  1  requester index of the response.
- rsp_result  out  W  ALU result.
- rsp_err  out  1  illegal op flag.
- cc_out  out  3  {ZF,SF,OF} architectural CC register.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0.
  - cc_out=3'b100 (ZF=1, SF=0, OF=0).
  - last_grant=1, so requester 0 wins first.
  - Any in-flight transaction is discarded and no response is produced.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, grant one requester; req_ready[g]=1 combinationally in this cycle only.
  - The handshake completes in the same cycle. Latch op, a, b and setcc from the granted port, then go to EXEC.
  - req_ready is 0 in every other state.
- Arbitration:
  - A single requester is granted directly.
  - When both are valid, grant the index != last_grant.
  - last_grant updates on each grant.
- EXEC (1 cycle): drive the latched operands into the ALU core, register result and flags, then go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_result and rsp_err are held stable until rsp_ready=1.
  - On the cycle with rsp_valid && rsp_ready, go to IDLE; rsp_valid drops the next cycle.
- Latency: request accepted at edge N gives rsp_valid at N+2. With rsp_ready tied high, throughput is one op every 3 cycles.
- Arithmetic (wrap modulo 2^W):
  - ADD (0): a+b.
  - SUB (1): b-a (Y86 subq semantics).
  - AND (2): a&b.
  - XOR (3): a^b.
- Flags:
  - ZF = (result==0).
  - SF = result[W-1].
  - OF for ADD = (a[W-1]==b[W-1]) && (result[W-1]!=a[W-1]).
  - OF for SUB = (a[W-1]!=b[W-1]) && (result[W-1]!=b[W-1]).
  - OF for AND/XOR = 0.
- CC update: cc_out is written at the end of EXEC, only if the latched setcc=1 and the op is legal. Otherwise cc_out holds.
- Illegal op (4..15): rsp_result=0, rsp_err=1, CC unchanged.
- Boundary cases:
  - A request dropped by its requester before being granted is simply not served.
  - A requester asserting valid while the block is busy waits; it must hold its inputs stable until req_ready.
  - Simultaneous grant and response cannot occur by construction.
  - rsp_ready high outside RESP is ignored.

Decomposition:
- Shared package alu_pkg:
  - ifun constants ALU_ADD=4'h0, ALU_SUB=4'h1, ALU_AND=4'h2, ALU_XOR=4'h3.
  - CC bit indices CC_ZF=2, CC_SF=1, CC_OF=0.
  - FSM state enum {IDLE, EXEC, RESP}.
- Sub-module alu_core: purely combinational.
  - Inputs: op, a, b.
  - Outputs: result, zf, sf, of, illegal.
  - Reused by the pipeline execute stage.
- Controller holds the FSM, arbiter, operand/result registers and CC register.

Test Plan:
- XOR: requester 0, a=64'hAAAA_AAAA_AAAA_AAAB, b=64'h5555_5555_5555_5555, setcc=1 -> at N+2 rsp_result=64'hFFFF_FFFF_FFFF_FFFE, rsp_id=0, cc_out=3'b010.
- ADD overflow: a=64'h7FFF_FFFF_FFFF_FFFF, b=1, setcc=1 -> rsp_result=64'h8000_0000_0000_0000, cc_out=3'b011. SUB a=15, b=15 -> result 0, cc_out=3'b100.
- Arbitration: both valid continuously after reset (op0 XOR 15^32, op1 AND 31&63) -> grants in order 0,1,0,1; responses 47, 31, 47, 31 with matching rsp_id.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_result stable, req_ready stays 0, busy=1. Raising rsp_ready -> IDLE next cycle.
- Illegal op 4'h7 with setcc=1 -> rsp_err=1, rsp_result=0, cc_out unchanged. setcc=0 ADD -> cc_out unchanged.
- Async reset asserted during EXEC (between clock edges) -> outputs return to reset values immediately, no response is ever issued for that request, and the next request is granted to requester 0.
